// File: rtl/bob_resolve_ctrl.sv
// bob_resolve_ctrl
// Sequences the Branch Ordering Buffer at branch resolution. Each resolved
// branch pops the oldest BOB entry. One cycle later the controller issues a
// predictor update. On a mispredict it also issues a fetch redirect, the
// recovery history/RAS state and a FLUSH_CYCLES-long flush that clears the BOB.
//
// Ports
//   clock, reset        : clock, synchronous active-high reset
//   ext_flush_i         : external flush, aborts any in-flight resolution
//   br_*_i / br_ready_o : resolution handshake from the execute branch unit
//   bob_*_i / bob_re_o  : BOB head entry and pop strobe
//   bob_flush_o         : BOB clear (same as flush_o)
//   upd_*_o             : predictor-table update pulse and payload
//   flush_o             : pipeline flush
//   redirect_*_o        : fetch redirect pulse and target
//   rst_*_o             : recovered BHR / local history / RAS pointer
//   err_o               : sticky error, resolution seen with an empty BOB
//   br_cnt_o, mis_cnt_o : resolved-branch and mispredict counters
module bob_resolve_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned INST_BYTES   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ext_flush_i,
  input  logic        br_valid_i,
  input  logic        br_taken_i,
  input  logic [63:0] br_target_i,
  output logic        br_ready_o,
  input  logic        bob_valid_i,
  input  logic [63:0] bob_pc_i,
  input  logic        bob_brdir_i,
  input  logic        bob_ch_we_i,
  input  logic        bob_ch_dir_i,
  input  logic [9:0]  bob_lochist_i,
  input  logic [11:0] bob_bhr_i,
  input  logic [3:0]  bob_rasptr_i,
  output logic        bob_re_o,
  output logic        bob_flush_o,
  output logic        upd_valid_o,
  output logic [63:0] upd_pc_o,
  output logic        upd_taken_o,
  output logic [9:0]  upd_lochist_o,
  output logic [11:0] upd_bhr_o,
  output logic        upd_ch_we_o,
  output logic        upd_ch_dir_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  output logic [11:0] rst_bhr_o,
  output logic [9:0]  rst_lochist_o,
  output logic [3:0]  rst_rasptr_o,
  output logic        err_o,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mis_cnt_o
);

  typedef enum logic [1:0] {IDLE, CHECK, RECOVER} state_t;

  // The CHECK cycle itself is the first flush cycle, so RECOVER covers the rest.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  flush_cnt, flush_cnt_nxt;

  logic [63:0] pc_p1, target_p1;
  logic        taken_p1, brdir_p1, ch_we_p1, ch_dir_p1;
  logic [9:0]  lochist_p1;
  logic [11:0] bhr_p1;
  logic [3:0]  rasptr_p1;

  logic        accept, err_set, check_live, mis;
  logic [63:0] fix_pc;
  logic [11:0] fix_bhr;
  logic [9:0]  fix_lochist;

  function automatic logic [63:0] fallthrough_pc(input logic [63:0] pc);
    return pc + 64'(INST_BYTES);
  endfunction

  // Recovery state is a pure function of the captured entry. The entry cannot
  // change during RECOVER, so these stay stable for the whole flush.
  assign mis         = taken_p1 ^ brdir_p1;
  assign fix_pc      = taken_p1 ? target_p1 : fallthrough_pc(pc_p1);
  assign fix_bhr     = {bhr_p1[10:0], taken_p1};
  assign fix_lochist = {lochist_p1[8:0], taken_p1};
  assign bob_flush_o = flush_o;

  always_comb begin
    state_nxt        = state;
    flush_cnt_nxt    = flush_cnt;
    accept           = 1'b0;
    err_set          = 1'b0;
    check_live       = 1'b0;
    br_ready_o       = 1'b0;
    bob_re_o         = 1'b0;
    upd_valid_o      = 1'b0;
    upd_pc_o         = '0;
    upd_taken_o      = 1'b0;
    upd_lochist_o    = '0;
    upd_bhr_o        = '0;
    upd_ch_we_o      = 1'b0;
    upd_ch_dir_o     = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    rst_bhr_o        = '0;
    rst_lochist_o    = '0;
    rst_rasptr_o     = '0;

    case (state)
      IDLE: begin
        br_ready_o = 1'b1;
        if (!ext_flush_i && br_valid_i) begin
          if (bob_valid_i) begin
            accept    = 1'b1;
            bob_re_o  = 1'b1;
            state_nxt = CHECK;
          end else begin
            err_set = 1'b1;
          end
        end
      end

      CHECK: begin
        state_nxt = IDLE;
        if (!ext_flush_i) begin
          check_live    = 1'b1;
          upd_valid_o   = 1'b1;
          upd_pc_o      = pc_p1;
          upd_taken_o   = taken_p1;
          upd_lochist_o = lochist_p1;
          upd_bhr_o     = bhr_p1;
          upd_ch_we_o   = ch_we_p1;
          upd_ch_dir_o  = ch_dir_p1;
          if (mis) begin
            flush_o          = 1'b1;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = fix_pc;
            rst_bhr_o        = fix_bhr;
            rst_lochist_o    = fix_lochist;
            rst_rasptr_o     = rasptr_p1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt     = RECOVER;
              flush_cnt_nxt = FLUSH_LOAD;
            end
          end
        end
      end

      RECOVER: begin
        flush_o       = 1'b1;
        redirect_pc_o = fix_pc;
        rst_bhr_o     = fix_bhr;
        rst_lochist_o = fix_lochist;
        rst_rasptr_o  = rasptr_p1;
        flush_cnt_nxt = flush_cnt - 4'd1;
        if (ext_flush_i || flush_cnt == 4'd1) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // stage p0 -> p1: capture the popped entry, update status and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      err_o      <= 1'b0;
      br_cnt_o   <= '0;
      mis_cnt_o  <= '0;
      pc_p1      <= '0;
      target_p1  <= '0;
      taken_p1   <= 1'b0;
      brdir_p1   <= 1'b0;
      ch_we_p1   <= 1'b0;
      ch_dir_p1  <= 1'b0;
      lochist_p1 <= '0;
      bhr_p1     <= '0;
      rasptr_p1  <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (err_set) begin
        err_o <= 1'b1;
      end
      if (check_live) begin
        br_cnt_o <= br_cnt_o + 32'd1;
        if (mis) begin
          mis_cnt_o <= mis_cnt_o + 32'd1;
        end
      end
      if (ext_flush_i) begin
        pc_p1      <= '0;
        target_p1  <= '0;
        taken_p1   <= 1'b0;
        brdir_p1   <= 1'b0;
        ch_we_p1   <= 1'b0;
        ch_dir_p1  <= 1'b0;
        lochist_p1 <= '0;
        bhr_p1     <= '0;
        rasptr_p1  <= '0;
      end else if (accept) begin
        pc_p1      <= bob_pc_i;
        target_p1  <= br_target_i;
        taken_p1   <= br_taken_i;
        brdir_p1   <= bob_brdir_i;
        ch_we_p1   <= bob_ch_we_i;
        ch_dir_p1  <= bob_ch_dir_i;
        lochist_p1 <= bob_lochist_i;
        bhr_p1     <= bob_bhr_i;
        rasptr_p1  <= bob_rasptr_i;
      end
    end
  end

endmodule

// File: tb/tb_bob_resolve_ctrl.sv
// Bench for bob_resolve_ctrl: instance a uses FLUSH_CYCLES=2 and instance b
// uses FLUSH_CYCLES=1. It applies a vector table, directed corner sequences,
// and a randomized run checked against a schedule-based reference model.
module tb_bob_resolve_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ext_flush_i, br_valid_i, br_taken_i, bob_valid_i;
  logic [63:0] br_target_i, bob_pc_i;
  logic        bob_brdir_i, bob_ch_we_i, bob_ch_dir_i;
  logic [9:0]  bob_lochist_i;
  logic [11:0] bob_bhr_i;
  logic [3:0]  bob_rasptr_i;

  logic        a_ready, a_re, a_bflush, a_uv, a_ut, a_uwe, a_udir, a_flush, a_rv, a_err;
  logic [63:0] a_upc, a_rpc;
  logic [9:0]  a_uloc, a_rloc;
  logic [11:0] a_ubhr, a_rbhr;
  logic [3:0]  a_ras;
  logic [31:0] a_brc, a_misc;

  logic        b_ready, b_re, b_bflush, b_uv, b_ut, b_uwe, b_udir, b_flush, b_rv, b_err;
  logic [63:0] b_upc, b_rpc;
  logic [9:0]  b_uloc, b_rloc;
  logic [11:0] b_ubhr, b_rbhr;
  logic [3:0]  b_ras;
  logic [31:0] b_brc, b_misc;

  always #5 clock = ~clock;

  bob_resolve_ctrl #(.FLUSH_CYCLES(2), .INST_BYTES(4)) dut_a (
    .clock(clock), .reset(reset), .ext_flush_i(ext_flush_i),
    .br_valid_i(br_valid_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .br_ready_o(a_ready), .bob_valid_i(bob_valid_i), .bob_pc_i(bob_pc_i),
    .bob_brdir_i(bob_brdir_i), .bob_ch_we_i(bob_ch_we_i), .bob_ch_dir_i(bob_ch_dir_i),
    .bob_lochist_i(bob_lochist_i), .bob_bhr_i(bob_bhr_i), .bob_rasptr_i(bob_rasptr_i),
    .bob_re_o(a_re), .bob_flush_o(a_bflush), .upd_valid_o(a_uv), .upd_pc_o(a_upc),
    .upd_taken_o(a_ut), .upd_lochist_o(a_uloc), .upd_bhr_o(a_ubhr),
    .upd_ch_we_o(a_uwe), .upd_ch_dir_o(a_udir), .flush_o(a_flush),
    .redirect_valid_o(a_rv), .redirect_pc_o(a_rpc), .rst_bhr_o(a_rbhr),
    .rst_lochist_o(a_rloc), .rst_rasptr_o(a_ras), .err_o(a_err),
    .br_cnt_o(a_brc), .mis_cnt_o(a_misc)
  );

  bob_resolve_ctrl #(.FLUSH_CYCLES(1), .INST_BYTES(4)) dut_b (
    .clock(clock), .reset(reset), .ext_flush_i(ext_flush_i),
    .br_valid_i(br_valid_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .br_ready_o(b_ready), .bob_valid_i(bob_valid_i), .bob_pc_i(bob_pc_i),
    .bob_brdir_i(bob_brdir_i), .bob_ch_we_i(bob_ch_we_i), .bob_ch_dir_i(bob_ch_dir_i),
    .bob_lochist_i(bob_lochist_i), .bob_bhr_i(bob_bhr_i), .bob_rasptr_i(bob_rasptr_i),
    .bob_re_o(b_re), .bob_flush_o(b_bflush), .upd_valid_o(b_uv), .upd_pc_o(b_upc),
    .upd_taken_o(b_ut), .upd_lochist_o(b_uloc), .upd_bhr_o(b_ubhr),
    .upd_ch_we_o(b_uwe), .upd_ch_dir_o(b_udir), .flush_o(b_flush),
    .redirect_valid_o(b_rv), .redirect_pc_o(b_rpc), .rst_bhr_o(b_rbhr),
    .rst_lochist_o(b_rloc), .rst_rasptr_o(b_ras), .err_o(b_err),
    .br_cnt_o(b_brc), .mis_cnt_o(b_misc)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_entry(input logic [63:0] pc, input logic brdir, input logic [11:0] bhr,
                             input logic [9:0] loc, input logic [3:0] ras, input logic chwe,
                             input logic chdir, input logic taken, input logic [63:0] target);
    bob_pc_i = pc; bob_brdir_i = brdir; bob_bhr_i = bhr; bob_lochist_i = loc;
    bob_rasptr_i = ras; bob_ch_we_i = chwe; bob_ch_dir_i = chdir;
    br_taken_i = taken; br_target_i = target;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clock);
    while (!(a_ready && b_ready) && k < 20) begin
      next_cycle();
      @(negedge clock);
      k++;
    end
    if (k >= 20) chk({name, "_idle_timeout"}, 64'(k), 64'd0);
    next_cycle();
  endtask

  typedef struct {
    logic [63:0] pc;
    logic        brdir;
    logic [11:0] bhr;
    logic [9:0]  loc;
    logic [3:0]  ras;
    logic        chwe;
    logic        chdir;
    logic        taken;
    logic [63:0] target;
    logic        exp_mis;
    logic [63:0] exp_rpc;
    logic [11:0] exp_rbhr;
    logic [9:0]  exp_rloc;
    int          exp_flush;
  } vec_t;

  vec_t vecs[5];

  // reference model state for the randomized run
  int          ready_at, upd_at, flush_last;
  bit          pend;
  logic [63:0] m_pc, m_target, h_rpc;
  logic        m_taken, m_brdir, m_chwe, m_chdir, m_err;
  logic [9:0]  m_loc, h_rloc;
  logic [11:0] m_bhr, h_rbhr;
  logic [3:0]  m_ras, h_ras;
  logic [31:0] m_br, m_mis;

  initial begin
    int lat, nfl, pops;
    logic [31:0] br0, mis0;
    logic [5:0] popmask;

    vecs[0] = '{64'h1000, 1'b1, 12'h000, 10'h000, 4'h0, 1'b1, 1'b1, 1'b1, 64'h2000,
                1'b0, 64'h0, 12'h000, 10'h000, 0};
    vecs[1] = '{64'h1000, 1'b1, 12'hABC, 10'h155, 4'h5, 1'b0, 1'b0, 1'b0, 64'h2000,
                1'b1, 64'h1004, 12'h578, 10'h2AA, 2};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 12'hFFF, 10'h3FF, 4'hF, 1'b1, 1'b0, 1'b0,
                64'h1234, 1'b1, 64'h0, 12'hFFE, 10'h3FE, 2};
    vecs[3] = '{64'h4000, 1'b0, 12'h001, 10'h200, 4'h3, 1'b0, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 12'h003, 10'h001, 2};
    vecs[4] = '{64'h8000, 1'b0, 12'h5A5, 10'h0F0, 4'h9, 1'b1, 1'b1, 1'b0, 64'h9000,
                1'b0, 64'h0, 12'h000, 10'h000, 0};

    reset = 1'b1; ext_flush_i = 1'b0; br_valid_i = 1'b0; bob_valid_i = 1'b0;
    drive_entry(64'h0, 1'b0, 12'h0, 10'h0, 4'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_re", a_re, 1'b0);
    chk("rst_flush", a_flush, 1'b0);
    chk("rst_upd", a_uv, 1'b0);
    chk("rst_redir", a_rv, 1'b0);
    chk("rst_rpc", a_rpc, 64'h0);
    chk("rst_bhr", a_rbhr, 12'h0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_brcnt", a_brc, 32'h0);
    chk("rst_miscnt", a_misc, 32'h0);
    chk("rst_b_ready", b_ready, 1'b1);
    next_cycle();

    // vector table on instance a
    for (int i = 0; i < 5; i++) begin
      drive_entry(vecs[i].pc, vecs[i].brdir, vecs[i].bhr, vecs[i].loc, vecs[i].ras,
                  vecs[i].chwe, vecs[i].chdir, vecs[i].taken, vecs[i].target);
      br_valid_i = 1'b1; bob_valid_i = 1'b1;
      @(negedge clock);
      chk($sformatf("v%0d_ready", i), a_ready, 1'b1);
      chk($sformatf("v%0d_re", i), a_re, 1'b1);
      chk($sformatf("v%0d_idle_rpc", i), a_rpc, 64'h0);
      next_cycle();
      br_valid_i = 1'b0; bob_valid_i = 1'b0;
      @(negedge clock);
      chk($sformatf("v%0d_upd", i), a_uv, 1'b1);
      chk($sformatf("v%0d_utaken", i), a_ut, vecs[i].taken);
      chk($sformatf("v%0d_upc", i), a_upc, vecs[i].pc);
      chk($sformatf("v%0d_ubhr", i), a_ubhr, vecs[i].bhr);
      chk($sformatf("v%0d_uloc", i), a_uloc, vecs[i].loc);
      chk($sformatf("v%0d_uwe", i), a_uwe, vecs[i].chwe);
      chk($sformatf("v%0d_udir", i), a_udir, vecs[i].chdir);
      chk($sformatf("v%0d_redir", i), a_rv, vecs[i].exp_mis);
      chk($sformatf("v%0d_rpc", i), a_rpc, vecs[i].exp_rpc);
      chk($sformatf("v%0d_rbhr", i), a_rbhr, vecs[i].exp_rbhr);
      chk($sformatf("v%0d_rloc", i), a_rloc, vecs[i].exp_rloc);
      chk($sformatf("v%0d_rras", i), a_ras, vecs[i].exp_mis ? vecs[i].ras : 4'h0);
      chk($sformatf("v%0d_bflush", i), a_bflush, vecs[i].exp_mis);
      chk($sformatf("v%0d_busy", i), a_ready, 1'b0);
      nfl = a_flush ? 1 : 0;
      lat = 1;
      while (lat < 20) begin
        next_cycle();
        @(negedge clock);
        lat++;
        if (a_ready) break;
        if (a_flush) begin
          nfl++;
          chk($sformatf("v%0d_hold_rbhr", i), a_rbhr, vecs[i].exp_rbhr);
        end
      end
      chk($sformatf("v%0d_flushlen", i), 64'(nfl), 64'(vecs[i].exp_flush));
      chk($sformatf("v%0d_latency", i), 64'(lat), vecs[i].exp_mis ? 64'd3 : 64'd2);
      chk($sformatf("v%0d_after_flush", i), a_flush, 1'b0);
      next_cycle();
    end
    @(negedge clock);
    chk("tbl_brcnt", a_brc, 32'd5);
    chk("tbl_miscnt", a_misc, 32'd3);
    wait_idle("tbl");

    // single-cycle flush on instance b, taken mispredict
    drive_entry(64'h5000, 1'b0, 12'h0F0, 10'h011, 4'h2, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
    br_valid_i = 1'b1; bob_valid_i = 1'b1;
    @(negedge clock);
    chk("fc1_re", b_re, 1'b1);
    next_cycle();
    br_valid_i = 1'b0; bob_valid_i = 1'b0;
    @(negedge clock);
    chk("fc1_flush", b_flush, 1'b1);
    chk("fc1_redir", b_rv, 1'b1);
    chk("fc1_rpc", b_rpc, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("fc1_rbhr", b_rbhr, 12'h1E1);
    next_cycle();
    @(negedge clock);
    chk("fc1_flush_end", b_flush, 1'b0);
    chk("fc1_ready", b_ready, 1'b1);
    chk("fc1_rpc_zero", b_rpc, 64'h0);
    chk("fc1_miscnt", b_misc, 32'd4);
    wait_idle("fc1");

    // empty BOB
    br0 = a_brc;
    br_valid_i = 1'b1; bob_valid_i = 1'b0;
    @(negedge clock);
    chk("empty_re", a_re, 1'b0);
    next_cycle();
    br_valid_i = 1'b0;
    @(negedge clock);
    chk("empty_err", a_err, 1'b1);
    chk("empty_upd", a_uv, 1'b0);
    chk("empty_ready", a_ready, 1'b1);
    next_cycle();
    @(negedge clock);
    chk("empty_brcnt", a_brc, br0);
    next_cycle();

    // external flush in the check cycle of a mispredict
    br0 = a_brc; mis0 = a_misc;
    drive_entry(64'h3000, 1'b1, 12'h123, 10'h045, 4'h7, 1'b1, 1'b1, 1'b0, 64'h7000);
    br_valid_i = 1'b1; bob_valid_i = 1'b1;
    @(negedge clock);
    chk("xf_re", a_re, 1'b1);
    next_cycle();
    br_valid_i = 1'b0; bob_valid_i = 1'b0; ext_flush_i = 1'b1;
    @(negedge clock);
    chk("xf_flush", a_flush, 1'b0);
    chk("xf_redir", a_rv, 1'b0);
    chk("xf_upd", a_uv, 1'b0);
    next_cycle();
    ext_flush_i = 1'b0;
    @(negedge clock);
    chk("xf_ready", a_ready, 1'b1);
    chk("xf_flush2", a_flush, 1'b0);
    chk("xf_miscnt", a_misc, mis0);
    chk("xf_brcnt", a_brc, br0);
    wait_idle("xf");

    // back-to-back correct predictions with br_valid_i held
    br0 = a_brc;
    popmask = '0;
    drive_entry(64'h6000, 1'b1, 12'h00F, 10'h00F, 4'h1, 1'b0, 1'b0, 1'b1, 64'h6100);
    br_valid_i = 1'b1; bob_valid_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (a_re) popmask[k] = 1'b1;
      next_cycle();
    end
    br_valid_i = 1'b0; bob_valid_i = 1'b0;
    @(negedge clock);
    pops = $countones(popmask);
    chk("b2b_popmask", popmask, 6'b010101);
    chk("b2b_pops", 64'(pops), 64'd3);
    chk("b2b_brcnt", a_brc, br0 + 32'd3);
    chk("err_sticky", a_err, 1'b1);
    wait_idle("b2b");

    // reset during RECOVER
    drive_entry(64'h7000, 1'b1, 12'h0, 10'h0, 4'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    br_valid_i = 1'b1; bob_valid_i = 1'b1;
    next_cycle();
    br_valid_i = 1'b0; bob_valid_i = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    chk("rr_recover_flush", a_flush, 1'b1);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("rr_flush_off", a_flush, 1'b0);
    chk("rr_ready", a_ready, 1'b1);
    chk("rr_brcnt", a_brc, 32'd0);
    chk("rr_err", a_err, 1'b0);
    next_cycle();

    // randomized run on instance a (two-cycle flush)
    ready_at = 0; upd_at = -1; flush_last = -1; pend = 1'b0;
    m_pc = '0; m_target = '0; m_taken = 1'b0; m_brdir = 1'b0; m_chwe = 1'b0; m_chdir = 1'b0;
    m_loc = '0; m_bhr = '0; m_ras = '0; m_err = 1'b0; m_br = '0; m_mis = '0;
    h_rpc = '0; h_rbhr = '0; h_rloc = '0; h_ras = '0;
    for (int c = 0; c < 800; c++) begin
      logic rdy, live, mis, rec, e_re, e_flush, e_redir;
      logic [63:0] e_rpc;
      logic [11:0] e_rbhr;
      logic [9:0]  e_rloc;
      logic [3:0]  e_ras;
      logic [31:0] hi, lo;
      br_valid_i  = 1'($urandom_range(0, 1));
      bob_valid_i = ($urandom_range(0, 9) != 0);
      ext_flush_i = ($urandom_range(0, 19) == 0);
      hi = $urandom(); lo = $urandom();
      bob_pc_i = {hi, lo};
      hi = $urandom(); lo = $urandom();
      br_target_i   = {hi, lo};
      br_taken_i    = 1'($urandom_range(0, 1));
      bob_brdir_i   = 1'($urandom_range(0, 1));
      bob_ch_we_i   = 1'($urandom_range(0, 1));
      bob_ch_dir_i  = 1'($urandom_range(0, 1));
      bob_lochist_i = 10'($urandom());
      bob_bhr_i     = 12'($urandom());
      bob_rasptr_i  = 4'($urandom());

      rdy  = (c >= ready_at);
      live = pend && (c == upd_at) && !ext_flush_i;
      mis  = m_taken ^ m_brdir;
      rec  = (c <= flush_last);
      e_re = rdy && br_valid_i && bob_valid_i && !ext_flush_i;
      e_flush = (live && mis) || rec;
      e_redir = live && mis;
      if (live && mis) begin
        e_rpc  = m_taken ? m_target : m_pc + 64'd4;
        e_rbhr = (m_bhr << 1) | 12'(m_taken);
        e_rloc = (m_loc << 1) | 10'(m_taken);
        e_ras  = m_ras;
      end else if (rec) begin
        e_rpc = h_rpc; e_rbhr = h_rbhr; e_rloc = h_rloc; e_ras = h_ras;
      end else begin
        e_rpc = '0; e_rbhr = '0; e_rloc = '0; e_ras = '0;
      end

      @(negedge clock);
      chk("r_ready", a_ready, rdy);
      chk("r_re", a_re, e_re);
      chk("r_upd", a_uv, live);
      chk("r_flush", a_flush, e_flush);
      chk("r_bflush", a_bflush, e_flush);
      chk("r_redir", a_rv, e_redir);
      chk("r_rpc", a_rpc, e_rpc);
      chk("r_rbhr", a_rbhr, e_rbhr);
      chk("r_rloc", a_rloc, e_rloc);
      chk("r_rras", a_ras, e_ras);
      chk("r_brcnt", a_brc, m_br);
      chk("r_miscnt", a_misc, m_mis);
      chk("r_err", a_err, m_err);
      if (live) begin
        chk("r_upc", a_upc, m_pc);
        chk("r_utaken", a_ut, m_taken);
        chk("r_ubhr", a_ubhr, m_bhr);
        chk("r_uloc", a_uloc, m_loc);
        chk("r_uwe", a_uwe, m_chwe);
        chk("r_udir", a_udir, m_chdir);
      end

      if (rdy && br_valid_i && !bob_valid_i && !ext_flush_i) m_err = 1'b1;
      if (ext_flush_i) begin
        pend = 1'b0; ready_at = c + 1; flush_last = -1;
      end else if (live) begin
        pend = 1'b0;
        m_br = m_br + 32'd1;
        if (mis) begin
          m_mis = m_mis + 32'd1;
          flush_last = c + 1;
          ready_at = c + 2;
          h_rpc = e_rpc; h_rbhr = e_rbhr; h_rloc = e_rloc; h_ras = e_ras;
        end else begin
          ready_at = c + 1;
        end
      end else if (e_re) begin
        pend = 1'b1; upd_at = c + 1; ready_at = c + 2;
        m_pc = bob_pc_i; m_target = br_target_i; m_taken = br_taken_i;
        m_brdir = bob_brdir_i; m_chwe = bob_ch_we_i; m_chdir = bob_ch_dir_i;
        m_loc = bob_lochist_i; m_bhr = bob_bhr_i; m_ras = bob_rasptr_i;
      end
      next_cycle();
    end
    br_valid_i = 1'b0; bob_valid_i = 1'b0; ext_flush_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
